// File: rtl/ucontrol_sequencer_if.sv
// ucontrol_sequencer_if: bus between the microcode sequencer and its control store / datapath.
//   master: sequencer side (drives CS address, datapath controls, memory strobes, halt, PSR)
//   slave : environment side (drives start, microword, ALU flags, IR fields, memory ready)
interface ucontrol_sequencer_if #(
  parameter int CS_ADDRWIDTH = 11,
  parameter int MIR_WIDTH = 41
);
  logic                    uControl_Start_InHigh;
  logic [MIR_WIDTH-1:0]    uControl_CS_Word_In;
  logic                    uControl_Overflow_InLow;
  logic                    uControl_Carry_InLow;
  logic                    uControl_Negative_InLow;
  logic                    uControl_Zero_InLow;
  logic                    uControl_ALU_Flags_Write_PCR;
  logic [7:0]              uControl_Reg_IR_OP;
  logic                    uControl_Reg_IR_IR13;
  logic                    uControl_DataMemory_Ready_In;
  logic [CS_ADDRWIDTH-1:0] uControl_CS_Address_Out;
  logic [5:0]              uControl_MUX_A_MIR;
  logic [5:0]              uControl_MUX_B_MIR;
  logic [5:0]              uControl_MUX_C_MIR;
  logic                    uControl_MUX_A_MIR_Selector;
  logic                    uControl_MUX_B_MIR_Selector;
  logic                    uControl_MUX_C_MIR_Selector;
  logic [3:0]              uControl_ALU_Selection_Out;
  logic                    uControl_DataMemory_Read_Out;
  logic                    uControl_DataMemory_Write_Out;
  logic                    uControl_DataMemory_Selector_Out;
  logic                    uControl_Halt_OutHigh;
  logic [3:0]              uControl_PSR_Out;
  modport master (
    input  uControl_Start_InHigh, uControl_CS_Word_In, uControl_Overflow_InLow, uControl_Carry_InLow,
           uControl_Negative_InLow, uControl_Zero_InLow, uControl_ALU_Flags_Write_PCR, uControl_Reg_IR_OP,
           uControl_Reg_IR_IR13, uControl_DataMemory_Ready_In,
    output uControl_CS_Address_Out, uControl_MUX_A_MIR, uControl_MUX_B_MIR, uControl_MUX_C_MIR,
           uControl_MUX_A_MIR_Selector, uControl_MUX_B_MIR_Selector, uControl_MUX_C_MIR_Selector,
           uControl_ALU_Selection_Out, uControl_DataMemory_Read_Out, uControl_DataMemory_Write_Out,
           uControl_DataMemory_Selector_Out, uControl_Halt_OutHigh, uControl_PSR_Out
  );
  modport slave (
    output uControl_Start_InHigh, uControl_CS_Word_In, uControl_Overflow_InLow, uControl_Carry_InLow,
           uControl_Negative_InLow, uControl_Zero_InLow, uControl_ALU_Flags_Write_PCR, uControl_Reg_IR_OP,
           uControl_Reg_IR_IR13, uControl_DataMemory_Ready_In,
    input  uControl_CS_Address_Out, uControl_MUX_A_MIR, uControl_MUX_B_MIR, uControl_MUX_C_MIR,
           uControl_MUX_A_MIR_Selector, uControl_MUX_B_MIR_Selector, uControl_MUX_C_MIR_Selector,
           uControl_ALU_Selection_Out, uControl_DataMemory_Read_Out, uControl_DataMemory_Write_Out,
           uControl_DataMemory_Selector_Out, uControl_Halt_OutHigh, uControl_PSR_Out
  );
endinterface

// File: rtl/ucontrol_sequencer.sv
// ucontrol_sequencer: microcode sequencer (CSAR/MIR/PSR) with memory wait and halt handling.
//   uControl_CLOCK_50    : clock, rising edge
//   uControl_RESET_InLow : asynchronous active-low reset
//   bus (master)         : control-store address/word, datapath controls, memory handshake, flags, halt, PSR
module ucontrol_sequencer #(
  parameter int CS_ADDRWIDTH = 11,
  parameter int MIR_WIDTH = 41
) (
  input logic uControl_CLOCK_50,
  input logic uControl_RESET_InLow,
  ucontrol_sequencer_if.master bus
);
  localparam int J = CS_ADDRWIDTH;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMWAIT, HALT} state_t;
  state_t state, stateNext;
  logic [J-1:0] csar, csarNext, jaddr, nextAddr;
  logic [MIR_WIDTH-1:0] mir, mirNext;
  logic [3:0] psr, psrNext;
  logic [2:0] cond;
  logic active, memAcc, waiting, taken, isHalt;
  assign jaddr = mir[J-1:0];
  assign cond = mir[J+2:J];
  assign memAcc = mir[J+8] | mir[J+7];
  assign active = state == EXEC || state == MEMWAIT;
  // Waiting covers the EXEC cycle with Ready low as well as MEMWAIT, so no register write leaks early.
  assign waiting = active && memAcc && !bus.uControl_DataMemory_Ready_In;
  assign isHalt = cond == 3'b110 && jaddr == csar;
  // Branch tests use the PSR held before this microword's own flag update; PSR is {N,Z,V,C}.
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b001: taken = psr[3];
      3'b010: taken = psr[2];
      3'b011: taken = psr[1];
      3'b100: taken = psr[0];
      3'b101: taken = bus.uControl_Reg_IR_IR13;
      3'b110: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
  assign nextAddr = cond == 3'b111 ? J'({1'b1, bus.uControl_Reg_IR_OP, 2'b00}) : taken ? jaddr : csar + J'(1);
  always_comb begin
    stateNext = state;
    csarNext = csar;
    mirNext = mir;
    psrNext = psr;
    case (state)
      IDLE, HALT: if (bus.uControl_Start_InHigh) begin
        stateNext = FETCH;
        csarNext = '0;
        psrNext = '0;
      end
      FETCH: begin
        stateNext = EXEC;
        mirNext = bus.uControl_CS_Word_In;
      end
      EXEC, MEMWAIT: if (waiting) stateNext = MEMWAIT;
      else begin
        stateNext = isHalt ? HALT : FETCH;
        csarNext = nextAddr;
        psrNext = bus.uControl_ALU_Flags_Write_PCR ? ~{bus.uControl_Negative_InLow, bus.uControl_Zero_InLow,
                  bus.uControl_Overflow_InLow, bus.uControl_Carry_InLow} : psr;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge uControl_CLOCK_50 or negedge uControl_RESET_InLow)
    if (!uControl_RESET_InLow) begin
      state <= IDLE;
      csar <= '0;
      mir <= '0;
      psr <= '0;
    end else begin
      state <= stateNext;
      csar <= csarNext;
      mir <= mirNext;
      psr <= psrNext;
    end
  assign bus.uControl_CS_Address_Out = csar;
  assign bus.uControl_MUX_A_MIR = active ? mir[J+29:J+24] : '0;
  assign bus.uControl_MUX_A_MIR_Selector = active & mir[J+23];
  assign bus.uControl_MUX_B_MIR = active ? mir[J+22:J+17] : '0;
  assign bus.uControl_MUX_B_MIR_Selector = active & mir[J+16];
  assign bus.uControl_MUX_C_MIR = active && !waiting ? mir[J+15:J+10] : '0;
  assign bus.uControl_MUX_C_MIR_Selector = active & !waiting & mir[J+9];
  assign bus.uControl_DataMemory_Read_Out = active & mir[J+8];
  assign bus.uControl_DataMemory_Write_Out = active & mir[J+7];
  assign bus.uControl_DataMemory_Selector_Out = active & mir[J+8];
  assign bus.uControl_ALU_Selection_Out = active ? mir[J+6:J+3] : '0;
  assign bus.uControl_Halt_OutHigh = state == HALT;
  assign bus.uControl_PSR_Out = psr;
endmodule

// File: tb/tb_ucontrol_sequencer.sv
// tb_ucontrol_sequencer: table-driven scoreboard bench for ucontrol_sequencer.
module tb_ucontrol_sequencer;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;
  ucontrol_sequencer_if bus ();
  ucontrol_sequencer dut (.uControl_CLOCK_50(clk), .uControl_RESET_InLow(rstN), .bus(bus));
  logic [40:0] rom [0:2047];
  assign bus.uControl_CS_Word_In = rom[bus.uControl_CS_Address_Out];
  typedef struct packed {
    logic [10:0] addr;
    logic rd;
    logic sel;
    logic [5:0] c;
    logic [3:0] alu;
    logic halt;
    logic [3:0] psr;
  } obs_t;
  typedef struct packed {
    logic start;
    logic ready;
    logic zn;
    logic fw;
    logic [7:0] ir;
    obs_t exp;
  } vec_t;
  obs_t expQ[$];
  vec_t tbl[$];
  int nTests = 0;
  int nFail = 0;
  function automatic logic [40:0] mw(input logic [5:0] c, input logic rd, input logic [3:0] alu,
                                     input logic [2:0] cond, input logic [10:0] j);
    return {6'd0, 1'b0, 6'd0, 1'b0, c, 1'b1, rd, 1'b0, alu, cond, j};
  endfunction
  function automatic vec_t v(input logic start, input logic ready, input logic zn, input logic fw,
                             input logic [7:0] ir, input logic [10:0] addr, input logic rd,
                             input logic [5:0] c, input logic [3:0] alu, input logic halt, input logic [3:0] psr);
    vec_t t;
    t.start = start;
    t.ready = ready;
    t.zn = zn;
    t.fw = fw;
    t.ir = ir;
    t.exp = '{addr: addr, rd: rd, sel: rd, c: c, alu: alu, halt: halt, psr: psr};
    return t;
  endfunction
  function automatic obs_t sample();
    obs_t o;
    o.addr = bus.uControl_CS_Address_Out;
    o.rd = bus.uControl_DataMemory_Read_Out;
    o.sel = bus.uControl_DataMemory_Selector_Out;
    o.c = bus.uControl_MUX_C_MIR;
    o.alu = bus.uControl_ALU_Selection_Out;
    o.halt = bus.uControl_Halt_OutHigh;
    o.psr = bus.uControl_PSR_Out;
    return o;
  endfunction
  task automatic check(input string name, input obs_t e);
    obs_t a;
    a = sample();
    nTests++;
    if (a !== e) begin
      nFail++;
      $display("FAIL %s: got addr=%h rd=%b sel=%b c=%h alu=%h halt=%b psr=%b, expected addr=%h rd=%b sel=%b c=%h alu=%h halt=%b psr=%b",
               name, a.addr, a.rd, a.sel, a.c, a.alu, a.halt, a.psr, e.addr, e.rd, e.sel, e.c, e.alu, e.halt, e.psr);
    end
  endtask
  task automatic apply(input string name, input vec_t t);
    @(negedge clk);
    bus.uControl_Start_InHigh = t.start;
    bus.uControl_DataMemory_Ready_In = t.ready;
    bus.uControl_Zero_InLow = t.zn;
    bus.uControl_ALU_Flags_Write_PCR = t.fw;
    bus.uControl_Reg_IR_OP = t.ir;
    expQ.push_back(t.exp);
    #1 check(name, expQ.pop_front());
  endtask
  task automatic resetPulse();
    @(negedge clk);
    rstN = 1'b0;
    bus.uControl_Start_InHigh = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    rom[11'h000] = mw(6'h00, 1'b0, 4'h0, 3'b000, 11'h000);
    rom[11'h001] = mw(6'h00, 1'b0, 4'h0, 3'b110, 11'h005);
    rom[11'h005] = mw(6'h11, 1'b0, 4'h3, 3'b000, 11'h000);
    rom[11'h006] = mw(6'h00, 1'b0, 4'h0, 3'b010, 11'h020);
    rom[11'h020] = mw(6'h00, 1'b0, 4'h0, 3'b000, 11'h000);
    rom[11'h021] = mw(6'h00, 1'b0, 4'h0, 3'b010, 11'h030);
    rom[11'h022] = mw(6'h00, 1'b0, 4'h0, 3'b111, 11'h000);
    rom[11'h600] = mw(6'h00, 1'b0, 4'h0, 3'b111, 11'h000);
    rom[11'h7FC] = mw(6'h2A, 1'b1, 4'h9, 3'b110, 11'h7FF);
    rom[11'h7FF] = mw(6'h07, 1'b0, 4'h0, 3'b000, 11'h000);
    bus.uControl_Start_InHigh = 1'b0;
    bus.uControl_Overflow_InLow = 1'b1;
    bus.uControl_Carry_InLow = 1'b1;
    bus.uControl_Negative_InLow = 1'b1;
    bus.uControl_Zero_InLow = 1'b1;
    bus.uControl_ALU_Flags_Write_PCR = 1'b0;
    bus.uControl_Reg_IR_OP = 8'h00;
    bus.uControl_Reg_IR_IR13 = 1'b0;
    bus.uControl_DataMemory_Ready_In = 1'b1;
    #1 check("reset_state", '0);
    //              st rdy zn fw ir     addr    rd c      alu   h  psr
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(1, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h001, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h001, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h005, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 0, 1, 8'h00, 11'h005, 0, 6'h11, 4'h3, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h006, 0, 6'h00, 4'h0, 0, 4'h4));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h006, 0, 6'h00, 4'h0, 0, 4'h4));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h020, 0, 6'h00, 4'h0, 0, 4'h4));
    tbl.push_back(v(0, 1, 1, 1, 8'h00, 11'h020, 0, 6'h00, 4'h0, 0, 4'h4));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h021, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 11'h021, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h80, 11'h022, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h80, 11'h022, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'h80, 11'h600, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'hFF, 11'h600, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 0, 1, 0, 8'hFF, 11'h7FC, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 0, 1, 0, 8'hFF, 11'h7FC, 1, 6'h00, 4'h9, 0, 4'h0));
    tbl.push_back(v(1, 0, 1, 0, 8'hFF, 11'h7FC, 1, 6'h00, 4'h9, 0, 4'h0));
    tbl.push_back(v(0, 0, 1, 0, 8'hFF, 11'h7FC, 1, 6'h00, 4'h9, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'hFF, 11'h7FC, 1, 6'h2A, 4'h9, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'hFF, 11'h7FF, 0, 6'h00, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'hFF, 11'h7FF, 0, 6'h07, 4'h0, 0, 4'h0));
    tbl.push_back(v(0, 1, 1, 0, 8'hFF, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    @(negedge clk);
    rstN = 1'b1;
    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);
    rom[11'h000] = mw(6'h00, 1'b0, 4'h0, 3'b110, 11'h010);
    rom[11'h010] = mw(6'h00, 1'b0, 4'h0, 3'b110, 11'h010);
    resetPulse();
    apply("halt_start", v(1, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("halt_fetch0", v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("halt_exec0", v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("halt_fetch10", v(0, 1, 1, 0, 8'h00, 11'h010, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("halt_exec10", v(0, 1, 0, 1, 8'h00, 11'h010, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("halt_held1", v(0, 1, 1, 0, 8'h00, 11'h010, 0, 6'h00, 4'h0, 1, 4'h4));
    apply("halt_held2", v(0, 1, 1, 0, 8'h00, 11'h010, 0, 6'h00, 4'h0, 1, 4'h4));
    apply("halt_restart", v(1, 1, 1, 0, 8'h00, 11'h010, 0, 6'h00, 4'h0, 1, 4'h4));
    apply("halt_resumed", v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    rom[11'h000] = mw(6'h05, 1'b1, 4'h2, 3'b000, 11'h000);
    resetPulse();
    apply("mw_start", v(1, 0, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("mw_fetch", v(0, 0, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("mw_exec", v(0, 0, 1, 0, 8'h00, 11'h000, 1, 6'h00, 4'h2, 0, 4'h0));
    apply("mw_wait", v(0, 0, 1, 0, 8'h00, 11'h000, 1, 6'h00, 4'h2, 0, 4'h0));
    rstN = 1'b0;
    #2 check("mw_async_reset", '0);
    @(negedge clk);
    rstN = 1'b1;
    apply("mw_idle1", v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("mw_idle2", v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("mw_restart", v(1, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("mw_refetch", v(0, 1, 1, 0, 8'h00, 11'h000, 0, 6'h00, 4'h0, 0, 4'h0));
    apply("mw_reexec", v(0, 1, 1, 0, 8'h00, 11'h000, 1, 6'h05, 4'h2, 0, 4'h0));
    apply("mw_next", v(0, 1, 1, 0, 8'h00, 11'h001, 0, 6'h00, 4'h0, 0, 4'h0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
